div_restoring_param: RTL and testbench

- Parametrised, multi-cycle restoring divider. It is the next-generation divide engine for the keypad calculator datapath.
- Sits between operand capture and the binary-to-BCD converter.
- Over the current 7-bit divider it adds:
  - a WIDTH generic;
  - a ready/start handshake that accepts back-to-back operations;
  - divide-by-zero detection with a fast path;
  - an optional signed mode.

---
 rtl/div_restoring_param.sv | 160 ++++++++++++++++
 tb/tb_div_restoring_param.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_restoring_param.sv
// Multi-cycle restoring divider with a ready/start handshake and a divide-by-zero fast path.
// Define DIV_SIGNED_EN for two's-complement operands; this adds one FIX cycle.
module div_restoring_param #(
    parameter int WIDTH = 7,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div0
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd3;
`ifdef DIV_SIGNED_EN
    localparam logic [1:0] FIX  = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;       // stored remainder always fits WIDTH bits
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             div0_q, div0_d;
`ifdef DIV_SIGNED_EN
    logic             sa_q, sa_d, sb_q, sb_d;
`endif

    logic [WIDTH:0]   p_sh, p_it;
    logic             ge;
    logic [WIDTH-1:0] dvd_it;
    logic [WIDTH-1:0] a_mag, b_mag;

    // One restoring step on the WIDTH+1-bit partial remainder.
    always_comb begin
        p_sh   = {p_q, dvd_q[WIDTH-1]};
        ge     = (p_sh >= {1'b0, dvs_q});
        p_it   = ge ? (p_sh - {1'b0, dvs_q}) : p_sh;
        dvd_it = {dvd_q[WIDTH-2:0], ge};
    end

`ifdef DIV_SIGNED_EN
    assign a_mag = A_in[WIDTH-1] ? (~A_in + 1'b1) : A_in;
    assign b_mag = B_in[WIDTH-1] ? (~B_in + 1'b1) : B_in;
`else
    assign a_mag = A_in;
    assign b_mag = B_in;
`endif

    assign ready = (state_q == IDLE) || (state_q == DONE);
    assign busy  = !ready;
    assign done  = (state_q == DONE);
    assign Q     = q_q;
    assign R     = r_q;
    assign div0  = div0_q;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        div0_d  = div0_q;
`ifdef DIV_SIGNED_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
`ifdef DIV_SIGNED_EN
                    sa_d = A_in[WIDTH-1];
                    sb_d = B_in[WIDTH-1];
`endif
                    dvd_d = a_mag;
                    dvs_d = b_mag;
                    if (B_in == '0) begin
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = A_in;
                        div0_d  = 1'b1;
                    end else begin
                        state_d = ITER;
                        p_d     = '0;
                        cnt_d   = CNT_W'(WIDTH);
                    end
                end
            end
            ITER: begin
                p_d   = p_it[WIDTH-1:0];
                dvd_d = dvd_it;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
`ifdef DIV_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = DONE;
                    q_d     = dvd_it;
                    r_d     = p_it[WIDTH-1:0];
                    div0_d  = 1'b0;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            // Truncating division: quotient sign from sA^sB, remainder follows dividend.
            FIX: begin
                state_d = DONE;
                q_d     = (sa_q ^ sb_q) ? (~dvd_q + 1'b1) : dvd_q;
                r_d     = sa_q ? (~p_q + 1'b1) : p_q;
                div0_d  = 1'b0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
`ifdef DIV_SIGNED_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_restoring_param.sv
// Scoreboard bench for div_restoring_param: stimulus pushes expected results, a monitor pops on done.
module tb_div_restoring_param;
`ifdef DIV_SIGNED_EN
    localparam int W   = 8;
    localparam int LAT = W + 2;
`else
    localparam int W   = 7;
    localparam int LAT = W + 1;
`endif

    logic         clk = 0;
    logic         rst = 0;
    logic         start = 0;
    logic [W-1:0] A_in = '0, B_in = '0;
    logic         ready, busy, done, div0;
    logic [W-1:0] Q, R;

    div_restoring_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A_in(A_in), .B_in(B_in),
        .ready(ready), .busy(busy), .done(done), .Q(Q), .R(R), .div0(div0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         d0;
        int           due;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_Q"}, 32'(Q), 32'(e.q));
                chk({e.name, "_R"}, 32'(R), 32'(e.r));
                chk({e.name, "_div0"}, 32'(div0), 32'(e.d0));
                chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic d0,
                        input int lat, input string nm);
        exp_t e;
        e.q = q; e.r = r; e.d0 = d0; e.due = cyc + lat - 1; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                         input logic [W-1:0] r, input logic d0, input int lat, input string nm);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin @(negedge clk); n++; end
        if (!ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
        A_in = a; B_in = b; start = 1;
        @(posedge clk); #1;
        push(q, r, d0, lat, nm);
        start = 0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); #1; n++; end
        chk({nm, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    localparam logic [W-1:0] ALL1 = '1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_Q",     32'(Q),     32'd0);
        chk("rst_R",     32'(R),     32'd0);
        chk("rst_div0",  32'(div0),  32'd0);
        @(negedge clk); rst = 1;

        // 100/7 with busy/ready tracking; a start pulse mid-iteration must be ignored.
        issue(W'(100), W'(7), W'(14), W'(2), 1'b0, LAT, "d100_7");
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            chk("iter_busy",  32'(busy),  32'd1);
            chk("iter_ready", 32'(ready), 32'd0);
            if (k == 3) begin start = 1; A_in = W'(1); B_in = W'(1); end
            if (k == 4) start = 0;
        end
        drain("d100_7");

        issue(W'(5), W'(0), ALL1, W'(5), 1'b1, 1, "d5_0");
        drain("d5_0");
        issue(W'(9), W'(3), W'(3), W'(0), 1'b0, LAT, "d9_3");
        drain("d9_3");
        issue(W'(3), W'(9), W'(0), W'(3), 1'b0, LAT, "d3_9");
        drain("d3_9");
        issue(W'(127), W'(1), W'(127), W'(0), 1'b0, LAT, "d127_1");
        drain("d127_1");

        // Back-to-back: start held; second operands presented in the DONE cycle.
        @(negedge clk);
        A_in = W'(50); B_in = W'(5); start = 1;
        @(posedge clk); #1;
        push(W'(10), W'(0), 1'b0, LAT, "b2b_50_5");
        A_in = W'(77); B_in = W'(2);
        begin
            int n = 0;
            @(negedge clk);
            while (!done && n < 50) begin @(negedge clk); n++; end
            chk("b2b_done_seen", 32'(done), 32'd1);
        end
        A_in = W'(51); B_in = W'(5);
        @(posedge clk); #1;
        push(W'(10), W'(1), 1'b0, LAT, "b2b_51_5");
        start = 0;
        drain("b2b");

        // Reset in the middle of 100/7 aborts without a done.
        @(negedge clk);
        A_in = W'(100); B_in = W'(7); start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst = 0;
        #1;
        chk("abort_Q",     32'(Q),     32'd0);
        chk("abort_R",     32'(R),     32'd0);
        chk("abort_div0",  32'(div0),  32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done",  32'(done),  32'd0);
        @(negedge clk); rst = 1;
        issue(W'(20), W'(6), W'(3), W'(2), 1'b0, LAT, "d20_6");
        drain("d20_6");

`ifdef DIV_SIGNED_EN
        issue(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, LAT, "s_m100_7");
        drain("s_m100_7");
        issue(8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, LAT, "s_100_m7");
        drain("s_100_m7");
        issue(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT, "s_min_m1");
        drain("s_min_m1");
`endif

        repeat (20) @(negedge clk);
        chk("final_idle_ready", 32'(ready), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
